// File: rtl/net_pkg.sv
// Shared mode encodings and sizing helpers for the playfield centre-line generator.
package net_pkg;

    localparam logic [1:0] NET_OFF    = 2'b00;
    localparam logic [1:0] NET_SOLID  = 2'b01;
    localparam logic [1:0] NET_DASH   = 2'b10;
    localparam logic [1:0] NET_SCROLL = 2'b11;

    function automatic int dash_period(input int dash_on, input int dash_off);
        return dash_on + dash_off;
    endfunction

    // Bits needed to hold the value n itself, never fewer than one.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/net_dash_seq.sv
// Per-line dash sequencer: counts active lines modulo the dash period and
// advances a per-frame starting phase when scrolling.
module net_dash_seq
    import net_pkg::*;
#(
    parameter int DASH_ON  = 4,
    parameter int DASH_OFF = 4
) (
    input  logic clk7_159,
    input  logic _reset,
    input  logic line_evt,
    input  logic frame_start,
    input  logic frame_end,
    input  logic scroll,
    output logic dash_lit
);

    localparam int PERIOD = dash_period(DASH_ON, DASH_OFF);
    localparam int LW     = cnt_width(PERIOD);
    localparam logic [LW-1:0] LAST   = LW'(PERIOD - 1);
    localparam logic [LW-1:0] ON_CNT = LW'(DASH_ON);

    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [LW-1:0] phase_q, phase_d;

    function automatic logic [LW-1:0] wrap_inc(input logic [LW-1:0] v);
        return (v == LAST) ? '0 : v + LW'(1);
    endfunction

    always_comb begin
        lcnt_d = lcnt_q;
        if (frame_start) begin
            lcnt_d = phase_q;
        end else if (line_evt) begin
            lcnt_d = wrap_inc(lcnt_q);
        end

        // Phase only carries meaning while scrolling; other modes pin it to 0.
        phase_d = phase_q;
        if (!scroll) begin
            phase_d = '0;
        end else if (frame_end) begin
            phase_d = wrap_inc(phase_q);
        end
    end

    always_ff @(posedge clk7_159) begin
        if (!_reset) begin
            lcnt_q  <= '0;
            phase_q <= '0;
        end else begin
            lcnt_q  <= lcnt_d;
            phase_q <= phase_d;
        end
    end

    assign dash_lit = (lcnt_q < ON_CNT);

endmodule

// File: rtl/net_gen.sv
// Configurable centre-line net: one or more stripes at fixed columns, shown
// off, solid, dashed or as a dash pattern that scrolls one line per frame.
module net_gen
    import net_pkg::*;
#(
    parameter int H_BITS      = 9,
    parameter int NET_X       = 256,
    parameter int NET_W       = 1,
    parameter int NUM_NETS    = 1,
    parameter int NET_SPACING = 0,
    parameter int DASH_ON     = 4,
    parameter int DASH_OFF    = 4
) (
    input  logic       clk7_159,
    input  logic       _reset,
    input  logic       hblank,
    input  logic       vblank,
    input  logic [1:0] mode,
    output logic       net
);

    localparam int HW   = H_BITS + 1;
    localparam int HMAX = 1 << H_BITS;

    logic [H_BITS-1:0] hcnt_q, hcnt_d;
    logic              hblank_q, vblank_q;
    logic [1:0]        mode_q, mode_d;
    logic              net_q, net_d;

    logic                line_evt, frame_start, frame_end;
    logic                dash_lit;
    logic [NUM_NETS-1:0] stripe_hit;
    logic                hit;

    // Lines that start inside vertical blank are not counted.
    assign line_evt    = hblank & ~hblank_q & ~vblank;
    assign frame_start = ~vblank & vblank_q;
    assign frame_end   = vblank & ~vblank_q;

    // Windows beyond the counter range are clamped to HMAX so they clip, never wrap.
    for (genvar k = 0; k < NUM_NETS; k++) begin : g_stripe
        localparam int LO_RAW  = NET_X + k * NET_SPACING;
        localparam int HI_RAW  = LO_RAW + NET_W;
        localparam int LO_CLIP = (LO_RAW > HMAX) ? HMAX : LO_RAW;
        localparam int HI_CLIP = (HI_RAW > HMAX) ? HMAX : HI_RAW;
        localparam logic [HW-1:0] LO = HW'(LO_CLIP);
        localparam logic [HW-1:0] HI = HW'(HI_CLIP);

        assign stripe_hit[k] = ({1'b0, hcnt_q} >= LO) && ({1'b0, hcnt_q} < HI);
    end

    assign hit = |stripe_hit;

    always_comb begin
        hcnt_d = hcnt_q;
        if (hblank) begin
            hcnt_d = '0;
        end else if (hcnt_q != '1) begin
            hcnt_d = hcnt_q + H_BITS'(1);
        end

        mode_d = frame_end ? mode : mode_q;

        net_d = hit & ~hblank & ~vblank &
                ((mode_q == NET_SOLID) | (mode_q[1] & dash_lit));
    end

    always_ff @(posedge clk7_159) begin
        if (!_reset) begin
            hcnt_q   <= '0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            mode_q   <= NET_OFF;
            net_q    <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            hblank_q <= hblank;
            vblank_q <= vblank;
            mode_q   <= mode_d;
            net_q    <= net_d;
        end
    end

    net_dash_seq #(
        .DASH_ON  (DASH_ON),
        .DASH_OFF (DASH_OFF)
    ) u_dash (
        .clk7_159    (clk7_159),
        ._reset      (_reset),
        .line_evt    (line_evt),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .scroll      (mode_q == NET_SCROLL),
        .dash_lit    (dash_lit)
    );

    assign net = net_q;

endmodule

// File: tb/tb_net_gen.sv
// Bench for net_gen: three differently configured instances share one video
// timing stream; a frame/line level model predicts every output cycle.
module tb_net_gen;

    localparam int ND = 3;
    localparam int X_OF   [ND] = '{256, 100, 500};
    localparam int W_OF   [ND] = '{1, 2, 20};
    localparam int N_OF   [ND] = '{1, 3, 2};
    localparam int S_OF   [ND] = '{0, 50, 400};
    localparam int ON_OF  [ND] = '{4, 3, 1};
    localparam int OFF_OF [ND] = '{4, 2, 0};
    localparam int VB_LINE = 20;

    logic       clk;
    logic       rst_n;
    logic       hblank;
    logic       vblank;
    logic [1:0] mode;
    logic       net_a, net_b, net_c;

    logic [ND-1:0] exp_q[$];
    int checks;
    int errors;
    int cur_line;
    int hits[ND][32];
    int line_len[32];

    int  m_mode;
    int  m_phase[ND];
    int  f_phase[ND];
    bit  m_vb_prev;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    net_gen u_a (
        .clk7_159 (clk), ._reset (rst_n), .hblank (hblank),
        .vblank (vblank), .mode (mode), .net (net_a)
    );

    net_gen #(
        .H_BITS (9), .NET_X (X_OF[1]), .NET_W (W_OF[1]), .NUM_NETS (N_OF[1]),
        .NET_SPACING (S_OF[1]), .DASH_ON (ON_OF[1]), .DASH_OFF (OFF_OF[1])
    ) u_b (
        .clk7_159 (clk), ._reset (rst_n), .hblank (hblank),
        .vblank (vblank), .mode (mode), .net (net_b)
    );

    net_gen #(
        .H_BITS (9), .NET_X (X_OF[2]), .NET_W (W_OF[2]), .NUM_NETS (N_OF[2]),
        .NET_SPACING (S_OF[2]), .DASH_ON (ON_OF[2]), .DASH_OFF (OFF_OF[2])
    ) u_c (
        .clk7_159 (clk), ._reset (rst_n), .hblank (hblank),
        .vblank (vblank), .mode (mode), .net (net_c)
    );

    // ---------------- reference model ----------------
    function automatic bit model_hit(input int d, input int px);
        int p;
        p = (px > 511) ? 511 : px;
        for (int k = 0; k < N_OF[d]; k++) begin
            if (p >= X_OF[d] + k * S_OF[d] && p < X_OF[d] + k * S_OF[d] + W_OF[d])
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic hb, input logic vb, input logic rst_in,
                        input int line, input int px);
        logic [ND-1:0] e;
        bit lit;
        @(negedge clk);
        hblank   = hb;
        vblank   = vb;
        rst_n    = rst_in;
        cur_line = line;
        e = '0;
        if (!rst_in) begin
            m_mode    = 0;
            m_vb_prev = 1'b0;
            for (int d = 0; d < ND; d++) begin
                m_phase[d] = 0;
                f_phase[d] = 0;
            end
        end else begin
            if (!vb && m_vb_prev)
                for (int d = 0; d < ND; d++) f_phase[d] = m_phase[d];
            for (int d = 0; d < ND; d++) begin
                lit = ((line + f_phase[d]) % (ON_OF[d] + OFF_OF[d])) < ON_OF[d];
                if (!hb && !vb && model_hit(d, px) && (m_mode == 1 || (m_mode >= 2 && lit)))
                    e[d] = 1'b1;
            end
            if (vb && !m_vb_prev) begin
                for (int d = 0; d < ND; d++) begin
                    if (mode != 2'b11) m_phase[d] = 0;
                    else if (m_mode == 3) m_phase[d] = (m_phase[d] + 1) % (ON_OF[d] + OFF_OF[d]);
                end
                m_mode = int'(mode);
            end
            m_vb_prev = vb;
        end
        exp_q.push_back(e);
    endtask

    task automatic run_line(input int line, input logic vb, input int act_len);
        int hb_len;
        hb_len = $urandom_range(3, 6);
        for (int i = 0; i < hb_len; i++) step(1'b1, vb, 1'b1, line, 0);
        for (int p = 0; p < act_len; p++) step(1'b0, vb, 1'b1, line, p);
    endtask

    task automatic clear_hits();
        for (int d = 0; d < ND; d++)
            for (int l = 0; l < 32; l++) hits[d][l] = 0;
    endtask

    task automatic run_frame(input int n_act, input int act_min, input int act_max,
                             input int sw_line, input logic [1:0] sw_mode);
        clear_hits();
        for (int l = 0; l < n_act; l++) begin
            if (l == sw_line) mode = sw_mode;
            line_len[l] = $urandom_range(act_min, act_max);
            run_line(l, 1'b0, line_len[l]);
        end
        run_line(VB_LINE, 1'b1, $urandom_range(262, 268));
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        logic [ND-1:0] e;
        logic [ND-1:0] got;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {net_c, net_b, net_a};
            checks++;
            if (got !== e) begin
                errors++;
                if (errors <= 10)
                    $display("FAIL net_cycle t=%0t line=%0d got=%b exp=%b", $time, cur_line, got, e);
            end
            for (int d = 0; d < ND; d++)
                if (got[d] === 1'b1) hits[d][cur_line]++;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        mode = 2'b01;
        for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b1, 0, 0);
        checks++;
        if ({net_c, net_b, net_a} !== 3'b000) begin
            errors++;
            $display("FAIL reset_net got=%b exp=000", {net_c, net_b, net_a});
        end
    endtask

    task automatic test_dark_after_reset();
        run_frame(9, 262, 270, -1, 2'b01);
        for (int l = 0; l < 9; l++) begin
            checks++;
            if (hits[0][l] + hits[1][l] + hits[2][l] !== 0) begin
                errors++;
                $display("FAIL dark_after_reset line=%0d got=%0d exp=0", l,
                         hits[0][l] + hits[1][l] + hits[2][l]);
            end
        end
    endtask

    task automatic test_solid();
        int n;
        n = $urandom_range(9, 11);
        run_frame(n, 262, 270, -1, 2'b01);
        for (int l = 0; l < n; l++) begin
            checks++;
            if (hits[0][l] !== 1 || hits[1][l] !== 6 || hits[2][l] !== 0) begin
                errors++;
                $display("FAIL solid_line line=%0d got=%0d/%0d/%0d exp=1/6/0", l,
                         hits[0][l], hits[1][l], hits[2][l]);
            end
        end
        checks++;
        if (hits[0][VB_LINE] !== 0) begin
            errors++;
            $display("FAIL solid_vblank got=%0d exp=0", hits[0][VB_LINE]);
        end
    endtask

    task automatic test_dash();
        int ea, eb;
        mode = 2'b10;
        run_frame(9, 262, 270, -1, 2'b10);
        for (int f = 0; f < 2; f++) begin
            run_frame(10, 262, 270, -1, 2'b10);
            for (int l = 0; l < 10; l++) begin
                ea = ((l % 8) < 4) ? 1 : 0;
                eb = ((l % 5) < 3) ? 6 : 0;
                checks++;
                if (hits[0][l] !== ea || hits[1][l] !== eb) begin
                    errors++;
                    $display("FAIL dash_line frame=%0d line=%0d got=%0d/%0d exp=%0d/%0d",
                             f, l, hits[0][l], hits[1][l], ea, eb);
                end
            end
        end
    endtask

    task automatic test_scroll();
        int ea, eb;
        logic [8:0] pat[10];
        mode = 2'b11;
        run_frame(9, 262, 266, -1, 2'b11);
        for (int f = 0; f < 10; f++) begin
            run_frame(9, 262, 266, -1, 2'b11);
            pat[f] = '0;
            for (int l = 0; l < 9; l++) begin
                ea = (((l + f % 8) % 8) < 4) ? 1 : 0;
                eb = (((l + f % 5) % 5) < 3) ? 6 : 0;
                pat[f][l] = (hits[0][l] != 0);
                checks++;
                if (hits[0][l] !== ea || hits[1][l] !== eb) begin
                    errors++;
                    $display("FAIL scroll_line frame=%0d line=%0d got=%0d/%0d exp=%0d/%0d",
                             f, l, hits[0][l], hits[1][l], ea, eb);
                end
            end
        end
        for (int f = 0; f < 2; f++) begin
            checks++;
            if (pat[f + 8] !== pat[f]) begin
                errors++;
                $display("FAIL scroll_repeat frame=%0d got=%b exp=%b", f + 8, pat[f + 8], pat[f]);
            end
        end
    endtask

    task automatic test_mode_switch();
        mode = 2'b01;
        run_frame(9, 262, 270, -1, 2'b01);
        run_frame(9, 262, 270, 4, 2'b00);
        for (int l = 0; l < 9; l++) begin
            checks++;
            if (hits[0][l] !== 1) begin
                errors++;
                $display("FAIL switch_tail line=%0d got=%0d exp=1", l, hits[0][l]);
            end
        end
        run_frame(9, 262, 270, -1, 2'b00);
        for (int l = 0; l < 9; l++) begin
            checks++;
            if (hits[0][l] + hits[1][l] !== 0) begin
                errors++;
                $display("FAIL switch_dark line=%0d got=%0d exp=0", l, hits[0][l] + hits[1][l]);
            end
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'b01;
        run_frame(9, 262, 270, -1, 2'b01);
        clear_hits();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 0, 0);
        for (int p = 0; p <= 100; p++) step(1'b0, 1'b0, 1'b1, 0, p);
        step(1'b0, 1'b0, 1'b0, 0, 101);
        checks++;
        if (net_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_before got=%b exp=1", net_b);
        end
        step(1'b0, 1'b0, 1'b1, 0, 102);
        checks++;
        if (net_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after got=%b exp=0", net_b);
        end
        for (int p = 103; p < 266; p++) step(1'b0, 1'b0, 1'b1, 0, p);
        for (int l = 1; l < 9; l++) run_line(l, 1'b0, 266);
        run_line(VB_LINE, 1'b1, 264);
        for (int l = 1; l < 9; l++) begin
            checks++;
            if (hits[0][l] + hits[1][l] !== 0) begin
                errors++;
                $display("FAIL reset_mid_dark line=%0d got=%0d exp=0", l, hits[0][l] + hits[1][l]);
            end
        end
        run_frame(9, 262, 270, -1, 2'b01);
        checks++;
        if (hits[0][0] !== 1 || hits[0][5] !== 1) begin
            errors++;
            $display("FAIL reset_mid_relit got=%0d/%0d exp=1/1", hits[0][0], hits[0][5]);
        end
    endtask

    task automatic test_saturate();
        run_frame(3, 600, 640, -1, 2'b01);
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (hits[2][l] !== line_len[l] - 500 || hits[0][l] !== 1 || hits[1][l] !== 6) begin
                errors++;
                $display("FAIL saturate line=%0d got=%0d/%0d/%0d exp=1/6/%0d", l,
                         hits[0][l], hits[1][l], hits[2][l], line_len[l] - 500);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        hblank    = 1'b0;
        vblank    = 1'b0;
        mode      = 2'b00;
        cur_line  = 0;
        m_mode    = 0;
        m_vb_prev = 1'b0;
        for (int d = 0; d < ND; d++) begin
            m_phase[d] = 0;
            f_phase[d] = 0;
        end
        clear_hits();

        test_reset();
        test_dark_after_reset();
        test_solid();
        test_dash();
        test_scroll();
        test_mode_switch();
        test_reset_mid();
        test_saturate();

        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
